turn_sequencer_mux: RTL and testbench

Parametrised turn sequencer and score selector for the multi-player game core. Tracks whose turn it is for 2 to MAX_PLAYERS players and advances on request, skipping eliminated players. Presents the current player's count, registered and coherent with the turn index. Detects a winner and stops the game. Sits between the per-player counters and the display/score path, and generalises the fixed 2/3/4-player lower-digit selector.

---
 rtl/turn_seq_pkg.sv | 21 ++
 rtl/turn_sequencer_mux_finder.sv | 32 +++
 rtl/turn_sequencer_mux.sv | 139 +++++++++++++
 tb/tb_turn_sequencer_mux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/turn_seq_pkg.sv
// Shared types and defaults for the multi-player turn sequencer.
// Player-count clamping lives here so every user applies the same limits.
package turn_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_MAX_PLAYERS = 4;
    localparam int DEF_CNT_W       = 5;
    localparam int DEF_WIN_CNT     = 24;

    function automatic int clamp_players(input int np, input int max_p);
        if (np < 2) return 2;
        if (np > max_p) return max_p;
        return np;
    endfunction

endpackage

// File: rtl/turn_sequencer_mux_finder.sv
// Rotate-priority scan: first active index strictly after base, modulo n.
// found stays low when no index other than base is active.
module next_active_finder #(
    parameter int MAX_PLAYERS = 4,
    parameter int PIDX_W      = $clog2(MAX_PLAYERS),
    parameter int NP_W        = $clog2(MAX_PLAYERS + 1)
) (
    input  logic [PIDX_W-1:0]      base,
    input  logic [NP_W-1:0]        n,
    input  logic [MAX_PLAYERS-1:0] active,
    output logic [PIDX_W-1:0]      next_idx,
    output logic                   found
);

    int idx;

    // Walk offsets from far to near so the nearest hit is written last.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = MAX_PLAYERS - 1; k >= 1; k--) begin
            idx = int'(base) + k;
            if (idx >= int'(n)) idx = idx - int'(n);
            if ((k < int'(n)) && (idx < MAX_PLAYERS) && active[idx[PIDX_W-1:0]]) begin
                found    = 1'b1;
                next_idx = PIDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/turn_sequencer_mux.sv
// Turn sequencer and current-score selector for 2..MAX_PLAYERS players.
// state   | meaning
// IDLE    | no game; cur_cnt follows player 0
// RUN     | game in progress; advance steps to the next active player
// DONE    | winner latched; waits for start
module turn_sequencer_mux
    import turn_seq_pkg::*;
#(
    parameter int MAX_PLAYERS = DEF_MAX_PLAYERS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_CNT     = DEF_WIN_CNT,
    parameter int PIDX_W      = $clog2(MAX_PLAYERS),
    parameter int NP_W        = $clog2(MAX_PLAYERS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NP_W-1:0]              num_players,
    input  logic                         advance,
    input  logic [MAX_PLAYERS-1:0]       skip_mask,
    input  logic [MAX_PLAYERS*CNT_W-1:0] p_cnt,
    output logic                         busy,
    output logic [PIDX_W-1:0]            cur_player,
    output logic [CNT_W-1:0]             cur_cnt,
    output logic                         round_wrap,
    output logic                         winner_valid,
    output logic [PIDX_W-1:0]            winner
);

    state_t                 state_q, state_d;
    logic [NP_W-1:0]        n_q, n_d, n_start;
    logic [PIDX_W-1:0]      cur_player_q, cur_player_d;
    logic [PIDX_W-1:0]      winner_q, winner_d;
    logic [CNT_W-1:0]       cur_cnt_q, cur_cnt_d;
    logic                   round_wrap_q, round_wrap_d;

    logic [MAX_PLAYERS-1:0] act_run, act_start;
    logic [PIDX_W-1:0]      adv_next, start_next, win_idx;
    logic                   adv_found, start_found, win_found;

    assign n_start = NP_W'(clamp_players(int'(num_players), MAX_PLAYERS));

    // Lowest active player at or above the win threshold takes the game.
    always_comb begin
        act_run   = '0;
        act_start = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            act_run[i]   = (i < int'(n_q)) && !skip_mask[i];
            act_start[i] = (i < int'(n_start)) && !skip_mask[i];
            if (act_run[i] && (p_cnt[i*CNT_W +: CNT_W] >= CNT_W'(WIN_CNT))) begin
                win_found = 1'b1;
                win_idx   = PIDX_W'(i);
            end
        end
    end

    next_active_finder #(.MAX_PLAYERS(MAX_PLAYERS), .PIDX_W(PIDX_W), .NP_W(NP_W)) u_adv_scan (
        .base     (cur_player_q),
        .n        (n_q),
        .active   (act_run),
        .next_idx (adv_next),
        .found    (adv_found)
    );

    next_active_finder #(.MAX_PLAYERS(MAX_PLAYERS), .PIDX_W(PIDX_W), .NP_W(NP_W)) u_start_scan (
        .base     ({PIDX_W{1'b0}}),
        .n        (n_start),
        .active   (act_start),
        .next_idx (start_next),
        .found    (start_found)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        cur_player_d = cur_player_q;
        winner_d     = winner_q;
        round_wrap_d = 1'b0;

        if (start) begin
            n_d      = n_start;
            winner_d = '0;
            // Player 0 is only chosen when it is the sole active player.
            if (start_found) begin
                state_d      = ST_RUN;
                cur_player_d = start_next;
            end else if (act_start[0]) begin
                state_d      = ST_RUN;
                cur_player_d = '0;
            end else begin
                state_d      = ST_DONE;
                cur_player_d = '0;
            end
        end else if (state_q == ST_RUN) begin
            if (win_found) begin
                state_d  = ST_DONE;
                winner_d = win_idx;
            end else if (advance) begin
                if (!adv_found) begin
                    state_d  = ST_DONE;
                    winner_d = cur_player_q;
                end else begin
                    cur_player_d = adv_next;
                    round_wrap_d = (adv_next <= cur_player_q);
                end
            end
        end

        cur_cnt_d = p_cnt[int'(cur_player_d)*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= NP_W'(2);
            cur_player_q <= '0;
            winner_q     <= '0;
            cur_cnt_q    <= '0;
            round_wrap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            cur_player_q <= cur_player_d;
            winner_q     <= winner_d;
            cur_cnt_q    <= cur_cnt_d;
            round_wrap_q <= round_wrap_d;
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign winner_valid = (state_q == ST_DONE);
    assign winner       = winner_q;
    assign cur_player   = cur_player_q;
    assign cur_cnt      = cur_cnt_q;
    assign round_wrap   = round_wrap_q;

endmodule

// File: tb/tb_turn_sequencer_mux.sv
// Directed and random checks of turn_sequencer_mux against a rule-level model.
module tb_turn_sequencer_mux;

    localparam int MP  = 4;
    localparam int CW  = 5;
    localparam int WIN = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    num_players = '0;
    logic          advance = 1'b0;
    logic [MP-1:0] skip_mask = '0;
    logic [MP*CW-1:0] p_cnt = '0;
    logic          busy, round_wrap, winner_valid;
    logic [1:0]    cur_player, winner;
    logic [CW-1:0] cur_cnt;

    turn_sequencer_mux dut (
        .clk(clk), .rst(rst), .start(start), .num_players(num_players),
        .advance(advance), .skip_mask(skip_mask), .p_cnt(p_cnt),
        .busy(busy), .cur_player(cur_player), .cur_cnt(cur_cnt),
        .round_wrap(round_wrap), .winner_valid(winner_valid), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt [MP];

    bit m_running, m_done, m_wrap;
    int m_n, m_cur, m_winner;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        assert (got === 32'(exp)) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_active(input int i, input logic [MP-1:0] sk);
        return (i < m_n) && !sk[i];
    endfunction

    task automatic model_edge(input bit s, input int np, input bit a, input logic [MP-1:0] sk);
        int p;
        bit hit;
        m_wrap = 0;
        if (s) begin
            m_n = (np < 2) ? 2 : ((np > MP) ? MP : np);
            m_winner = 0;
            hit = 0;
            for (int k = 1; k <= m_n && !hit; k++) begin
                p = k % m_n;
                if (is_active(p, sk)) begin hit = 1; m_cur = p; end
            end
            m_running = hit;
            m_done = !hit;
            if (!hit) m_cur = 0;
        end else if (m_running) begin
            hit = 0;
            for (int i = 0; i < m_n && !hit; i++)
                if (is_active(i, sk) && cnt[i] >= WIN) begin hit = 1; m_winner = i; end
            if (hit) begin
                m_running = 0; m_done = 1;
            end else if (a) begin
                for (int k = 1; k < m_n && !hit; k++) begin
                    p = (m_cur + k) % m_n;
                    if (is_active(p, sk)) hit = 1;
                end
                if (!hit) begin
                    m_running = 0; m_done = 1; m_winner = m_cur;
                end else begin
                    m_wrap = (p <= m_cur);
                    m_cur = p;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), int'(m_running));
        chk("cur_player", 32'(cur_player), m_cur);
        chk("cur_cnt", 32'(cur_cnt), cnt[m_cur]);
        chk("round_wrap", 32'(round_wrap), int'(m_wrap));
        chk("winner_valid", 32'(winner_valid), int'(m_done));
        chk("winner", 32'(winner), m_winner);
    endtask

    task automatic step(input bit s, input int np, input bit a, input logic [MP-1:0] sk);
        start = s;
        num_players = 3'(np);
        advance = a;
        skip_mask = sk;
        for (int i = 0; i < MP; i++) p_cnt[i*CW +: CW] = CW'(cnt[i]);
        @(posedge clk);
        model_edge(s, np, a, sk);
        #1;
        start = 0;
        advance = 0;
        check_all();
    endtask

    task automatic model_reset();
        m_running = 0; m_done = 0; m_wrap = 0; m_cur = 0; m_winner = 0; m_n = 2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cur"}, 32'(cur_player), 0);
        chk({tag, "_cnt"}, 32'(cur_cnt), 0);
        chk({tag, "_wrap"}, 32'(round_wrap), 0);
        chk({tag, "_wv"}, 32'(winner_valid), 0);
        chk({tag, "_win"}, 32'(winner), 0);
    endtask

    task automatic set_cnts(input int c0, input int c1, input int c2, input int c3);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    endtask

    initial begin
        model_reset();
        set_cnts(3, 7, 11, 15);
        #12;
        chk_zero("reset");
        rst = 0;

        // 4 players, no skips
        step(1, 4, 0, 4'b0000);
        chk("t1_start_cur", 32'(cur_player), 1);
        chk("t1_start_cnt", 32'(cur_cnt), 7);
        step(0, 0, 1, 4'b0000); chk("t1_a1", 32'(cur_player), 2);
        step(0, 0, 1, 4'b0000); chk("t1_a2", 32'(cur_player), 3);
        step(0, 0, 1, 4'b0000); chk("t1_a3", 32'(cur_player), 0);
        chk("t1_wrap", 32'(round_wrap), 1);
        chk("t1_cnt0", 32'(cur_cnt), 3);
        step(0, 0, 1, 4'b0000); chk("t1_a4", 32'(cur_player), 1);
        chk("t1_nowrap", 32'(round_wrap), 0);

        // 3 players, player 2 eliminated
        step(1, 3, 0, 4'b0100); chk("t2_start", 32'(cur_player), 1);
        step(0, 0, 1, 4'b0100); chk("t2_a1", 32'(cur_player), 0);
        chk("t2_wrap1", 32'(round_wrap), 1);
        step(0, 0, 1, 4'b0100); chk("t2_a2", 32'(cur_player), 1);
        step(0, 0, 1, 4'b0100); chk("t2_a3", 32'(cur_player), 0);
        chk("t2_wrap3", 32'(round_wrap), 1);

        // clamping
        step(1, 7, 0, 4'b0000);
        step(0, 0, 1, 4'b0000);
        step(0, 0, 1, 4'b0000); chk("t3_clamp_hi", 32'(cur_player), 3);
        step(1, 1, 0, 4'b0000); chk("t3_lo_start", 32'(cur_player), 1);
        step(0, 0, 1, 4'b0000); chk("t3_lo_a1", 32'(cur_player), 0);
        step(0, 0, 1, 4'b0000); chk("t3_lo_a2", 32'(cur_player), 1);

        // win beats a same-cycle advance
        step(1, 4, 0, 4'b0000);
        set_cnts(3, 7, 24, 30);
        step(0, 0, 1, 4'b0000);
        chk("t4_wv", 32'(winner_valid), 1);
        chk("t4_winner", 32'(winner), 2);
        chk("t4_cur", 32'(cur_player), 1);
        chk("t4_busy", 32'(busy), 0);
        step(0, 0, 1, 4'b0000); chk("t4_frozen", 32'(cur_player), 1);
        step(1, 4, 0, 4'b0000);
        chk("t6_restart_wv", 32'(winner_valid), 0);
        chk("t6_restart_cur", 32'(cur_player), 1);
        chk("t6_restart_busy", 32'(busy), 1);
        set_cnts(3, 7, 11, 15);
        step(0, 0, 0, 4'b0000);

        // last player standing
        step(1, 3, 0, 4'b0000);
        step(0, 0, 1, 4'b0000); chk("t5_cur2", 32'(cur_player), 2);
        step(0, 0, 1, 4'b0011);
        chk("t5_wv", 32'(winner_valid), 1);
        chk("t5_winner", 32'(winner), 2);

        // asynchronous reset mid-game
        step(1, 4, 0, 4'b0000);
        step(0, 0, 1, 4'b0000);
        rst = 1;
        #1;
        chk_zero("midrst");
        model_reset();
        #1 rst = 0;
        step(0, 0, 1, 4'b0000);

        // random traffic
        begin
            logic [MP-1:0] sk = '0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 9) == 0) sk = MP'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) begin
                    int who = $urandom_range(0, MP - 1);
                    cnt[who] = ($urandom_range(0, 29) == 0) ? $urandom_range(24, 31)
                                                           : $urandom_range(0, 23);
                end
                if ($urandom_range(0, 39) == 0) set_cnts(1, 2, 3, 4);
                step(($urandom_range(0, 19) == 0) || (m_done && $urandom_range(0, 3) == 0),
                     $urandom_range(0, 7), $urandom_range(0, 1) == 1, sk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
